cdb_broadcast_arbiter: RTL and testbench
========================================

// Module: cdb_broadcast_arbiter
// PURPOSE
//  Shares the common data bus (CDB) among NUM_FU functional units. Each FU holds fu_done high
//  with its result/tag until queued; this block round-robin selects one finished FU per cycle,
//  returns fu_queued so that FU can go idle, buffers the result in a DEPTH-entry broadcast
//  queue, and drives CDB entries in order under a valid/ready handshake.
// PARAMETERS
//  NUM_FU      4   number of functional units sharing the CDB (>= 2)
//  DATA_WIDTH  32  result width
//  TAG_WIDTH   7   execution tag width
//  DEPTH       8   broadcast queue entries (power of 2, >= 2)
// PORTS
//  clk        in   1                      clock, all state on posedge
//  rst        in   1                      asynchronous, active-low reset
//  fu_done    in   NUM_FU                 FU i has a finished result (level, held until queued)
//  fu_issue   in   NUM_FU                 FU i ce this cycle (new op dispatched)
//  fu_tag     in   NUM_FU*TAG_WIDTH       FU i tag at [i*TAG_WIDTH +: TAG_WIDTH]
//  fu_result  in   NUM_FU*DATA_WIDTH      FU i result at [i*DATA_WIDTH +: DATA_WIDTH]
//  fu_queued  out  NUM_FU                 one-hot grant: FU i result accepted this cycle
//  cdb_valid  out  1                      queue head valid
//  cdb_tag    out  TAG_WIDTH              queue head tag
//  cdb_data   out  DATA_WIDTH             queue head result
//  cdb_ready  in   1                      consumer takes head this cycle
//  count      out  $clog2(DEPTH+1)        entries in queue
//  full       out  1                      count == DEPTH
//  empty      out  1                      count == 0
// BEHAVIOUR
//  - Reset (rst low, async): count=0, rd/wr pointers=0, rr pointer=0, sent[]=0; cdb_valid=0,
//    full=0, empty=1, fu_queued=0 (forced 0 while rst low). Queue RAM not cleared.
//  - sent[i]: set on grant to FU i; cleared when fu_issue[i]=1 (clear wins over set).
//    Prevents re-queuing a held fu_done after acceptance.
//  - eligible[i] = fu_done[i] & ~sent[i] & ~fu_issue[i].
//  - Space: can_push = (count < DEPTH) | pop. pop = cdb_valid & cdb_ready.
//  - Grant (combinational): if can_push, the first eligible FU scanning from rr pointer
//    upward with wrap; at most one bit of fu_queued set. No grant if none eligible or no space.
//  - On grant to i: at the same posedge write {fu_tag[i], fu_result[i]} at wr pointer,
//    wr pointer +1 (wraps DEPTH-1 -> 0), sent[i]<=1, rr pointer <= (i+1) mod NUM_FU.
//    No grant -> rr pointer unchanged.
//  - Queue is first-word-fall-through: cdb_valid = ~empty; cdb_tag/cdb_data = entry at rd
//    pointer, stable while cdb_valid & ~cdb_ready. Pop advances rd pointer with wrap.
//  - Latency: FU result granted in cycle t appears on CDB in cycle t+1 at earliest (empty queue).
//  - count: +1 push only, -1 pop only, unchanged on simultaneous push+pop (incl. full and
//    count==1). Push when full allowed only with same-cycle pop. Pop when empty impossible.
//  - cdb_ready while cdb_valid=0 is ignored. Order on CDB = grant order.
//  - Reset mid-operation: all queued entries discarded, sent[] cleared; FUs still holding
//    fu_done re-arbitrate from FU 0 after reset release.
// TESTING
//  1 Reset: rst low with fu_done=4'b1111 -> fu_queued=0, cdb_valid=0, empty=1, count=0.
//  2 Round robin: fu_done=4'b1111 held, cdb_ready=1 -> grants FU0,1,2,3 in cycles 1-4, each
//    once; tags 0x10..0x13 appear on CDB cycles 2-5; no second grant until fu_issue[i].
//  3 Fairness: FU0,FU2 re-issued and re-done each cycle -> grants alternate 0,2,0,2; FU2
//    never starved; rr pointer after FU0 grant = 1.
//  4 Full: cdb_ready=0, 9 FUs-worth of results (reissue) -> count reaches 8, full=1,
//    fu_queued=0 while full; raise cdb_ready -> push+pop same cycle, count stays 8.
//  5 Wrap: 20 push/pop pairs, DEPTH=8 -> CDB tag sequence equals grant sequence, no loss.
//  6 Async reset mid-op: count=5, drop rst between edges -> count=0, cdb_valid=0 immediately.

Source files
------------

// File: rtl/cdb_broadcast_arbiter.sv
// cdb_broadcast_arbiter: round-robin selects one finished functional unit per cycle,
// acknowledges it on fu_queued, and buffers its tag/result in a first-word-fall-through
// broadcast queue that drives the common data bus under a valid/ready handshake.
module cdb_broadcast_arbiter #(
  parameter int NUM_FU     = 4,
  parameter int DATA_WIDTH = 32,
  parameter int TAG_WIDTH  = 7,
  parameter int DEPTH      = 8
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [NUM_FU-1:0]               fu_done,
  input  logic [NUM_FU-1:0]               fu_issue,
  input  logic [NUM_FU*TAG_WIDTH-1:0]     fu_tag,
  input  logic [NUM_FU*DATA_WIDTH-1:0]    fu_result,
  output logic [NUM_FU-1:0]               fu_queued,
  output logic                            cdb_valid,
  output logic [TAG_WIDTH-1:0]            cdb_tag,
  output logic [DATA_WIDTH-1:0]           cdb_data,
  input  logic                            cdb_ready,
  output logic [$clog2(DEPTH+1)-1:0]      count,
  output logic                            full,
  output logic                            empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH+1);
  localparam int RR_W  = $clog2(NUM_FU);
  localparam int ENT_W = TAG_WIDTH + DATA_WIDTH;
  localparam logic [RR_W-1:0]  RR_LAST   = RR_W'(NUM_FU - 1);
  localparam logic [CNT_W-1:0] CNT_DEPTH = CNT_W'(DEPTH);

  logic [RR_W-1:0]   rr_q, rr_d;
  logic [NUM_FU-1:0] sent_q, sent_d;
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [ENT_W-1:0]  mem_q [DEPTH];

  logic [NUM_FU-1:0] eligible;
  logic [NUM_FU-1:0] grant_vec;
  logic [RR_W-1:0]   gnt_idx;
  logic [RR_W:0]     scan_idx;
  logic              grant_any;
  logic              pop;
  logic              can_push;
  logic [ENT_W-1:0]  wr_entry;

  assign eligible  = fu_done & ~sent_q & ~fu_issue;
  assign empty     = (count_q == '0);
  assign full      = (count_q == CNT_DEPTH);
  assign cdb_valid = ~empty;
  assign pop       = cdb_valid & cdb_ready;
  assign can_push  = (count_q < CNT_DEPTH) | pop;
  assign count     = count_q;
  assign cdb_tag   = mem_q[rd_ptr_q][DATA_WIDTH +: TAG_WIDTH];
  assign cdb_data  = mem_q[rd_ptr_q][DATA_WIDTH-1:0];
  assign fu_queued = grant_vec;

  // Round-robin pick: first eligible FU at or after rr_q, suppressed without space or in reset.
  always_comb begin
    grant_vec = '0;
    gnt_idx   = '0;
    grant_any = 1'b0;
    scan_idx  = '0;
    for (int k = 0; k < NUM_FU; k++) begin
      scan_idx = {1'b0, rr_q} + (RR_W+1)'(k);
      if (scan_idx >= (RR_W+1)'(NUM_FU)) begin
        scan_idx = scan_idx - (RR_W+1)'(NUM_FU);
      end
      if (!grant_any && eligible[scan_idx[RR_W-1:0]]) begin
        grant_any = 1'b1;
        gnt_idx   = scan_idx[RR_W-1:0];
      end
    end
    if (!can_push || !rst) begin
      grant_any = 1'b0;
    end
    if (grant_any) begin
      grant_vec[gnt_idx] = 1'b1;
    end
  end

  // Next-state for pointers, occupancy and per-FU accepted flags.
  always_comb begin
    rr_d     = rr_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    wr_entry = {fu_tag[gnt_idx*TAG_WIDTH +: TAG_WIDTH],
                fu_result[gnt_idx*DATA_WIDTH +: DATA_WIDTH]};
    // issue clears the flag even if a grant would set it the same cycle
    sent_d   = (sent_q | grant_vec) & ~fu_issue;
    if (grant_any) begin
      rr_d     = (gnt_idx == RR_LAST) ? '0 : gnt_idx + 1'b1;
      wr_ptr_d = wr_ptr_q + 1'b1;
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    if (grant_any && !pop) begin
      count_d = count_q + 1'b1;
    end else if (pop && !grant_any) begin
      count_d = count_q - 1'b1;
    end
  end

  // Control state register; async reset discards queued entries and arbitration history.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rr_q     <= '0;
      sent_q   <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rr_q     <= rr_d;
      sent_q   <= sent_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Queue storage; contents are don't-care until written, so no reset.
  always_ff @(posedge clk) begin
    if (grant_any) begin
      mem_q[wr_ptr_q] <= wr_entry;
    end
  end

endmodule

// File: tb/tb_cdb_broadcast_arbiter.sv
// tb_cdb_broadcast_arbiter: directed scenarios plus randomized traffic, checked every cycle
// against a queue-based model of the arbiter, with literal expectations pinning the model.
module tb_cdb_broadcast_arbiter;
  localparam int NF = 4;
  localparam int DW = 32;
  localparam int TW = 7;
  localparam int DP = 8;

  logic           clk = 1'b0;
  logic           rst;
  logic [NF-1:0]  fu_done, fu_issue, fu_queued;
  logic [NF*TW-1:0] fu_tag;
  logic [NF*DW-1:0] fu_result;
  logic           cdb_valid, cdb_ready, full, empty;
  logic [TW-1:0]  cdb_tag;
  logic [DW-1:0]  cdb_data;
  logic [3:0]     count;

  cdb_broadcast_arbiter #(.NUM_FU(NF), .DATA_WIDTH(DW), .TAG_WIDTH(TW), .DEPTH(DP)) dut (
    .clk(clk), .rst(rst), .fu_done(fu_done), .fu_issue(fu_issue), .fu_tag(fu_tag),
    .fu_result(fu_result), .fu_queued(fu_queued), .cdb_valid(cdb_valid), .cdb_tag(cdb_tag),
    .cdb_data(cdb_data), .cdb_ready(cdb_ready), .count(count), .full(full), .empty(empty)
  );

  // Free-running clock.
  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
  endtask

  function automatic int oh2idx(input logic [NF-1:0] v);
    case (v)
      4'b0000: return -1;
      4'b0001: return 0;
      4'b0010: return 1;
      4'b0100: return 2;
      4'b1000: return 3;
      default: return -2;
    endcase
  endfunction

  // Behavioural model: queue of {tag,result}, accepted flags and rotating start index.
  logic [TW+DW-1:0] mq[$];
  bit               m_sent[NF];
  int               m_rr;
  int               rec_g;
  bit               rec_pop, rec_valid;
  logic [TW+DW-1:0] rec_entry, head;
  logic [NF-1:0]    rec_issue;
  int               m_g, m_i;
  bit               m_pop, m_can_push;
  int               dut_gnt[$];
  int               dut_cdb[$];
  bit               log_en;

  // Compare process: outputs are settled mid-cycle, check them against the model.
  always @(negedge clk) begin
    if (!rst) begin
      mq.delete();
      for (int k = 0; k < NF; k++) m_sent[k] = 0;
      m_rr = 0;
      rec_valid = 0;
      check("rst_queued", fu_queued, 0);
      check("rst_valid", cdb_valid, 0);
      check("rst_count", count, 0);
      check("rst_empty", empty, 1);
      check("rst_full", full, 0);
    end else begin
      m_pop      = (mq.size() > 0) && cdb_ready;
      m_can_push = (mq.size() < DP) || m_pop;
      m_g = -1;
      if (m_can_push) begin
        for (int k = 0; k < NF; k++) begin
          m_i = (m_rr + k) % NF;
          if (m_g < 0 && fu_done[m_i] && !m_sent[m_i] && !fu_issue[m_i]) m_g = m_i;
        end
      end
      check("fu_queued", fu_queued, (m_g < 0) ? 4'b0000 : 4'(1 << m_g));
      check("cdb_valid", cdb_valid, mq.size() > 0);
      if (mq.size() > 0) begin
        head = mq[0];
        check("cdb_tag", cdb_tag, head[TW+DW-1:DW]);
        check("cdb_data", cdb_data, head[DW-1:0]);
      end
      check("count", count, mq.size());
      check("full", full, mq.size() == DP);
      check("empty", empty, mq.size() == 0);
      if (log_en) begin
        dut_gnt.push_back(oh2idx(fu_queued));
        if (cdb_valid && cdb_ready) dut_cdb.push_back(int'(cdb_tag));
      end
      rec_g     = m_g;
      rec_pop   = m_pop;
      rec_issue = fu_issue;
      if (m_g >= 0) rec_entry = {fu_tag[m_g*TW +: TW], fu_result[m_g*DW +: DW]};
      rec_valid = 1;
    end
  end

  // Model update at the clock edge using what the compare process observed.
  always @(posedge clk) begin
    if (rst && rec_valid) begin
      if (rec_pop) void'(mq.pop_front());
      if (rec_g >= 0) begin
        mq.push_back(rec_entry);
        m_sent[rec_g] = 1;
        m_rr = (rec_g + 1) % NF;
      end
      for (int k = 0; k < NF; k++) if (rec_issue[k]) m_sent[k] = 0;
      rec_valid = 0;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_fixed_tags();
    for (int k = 0; k < NF; k++) begin
      fu_tag[k*TW +: TW]    = TW'(8'h10 + k);
      fu_result[k*DW +: DW] = 32'hA000_0000 + k;
    end
  endtask

  task automatic clear_logs();
    dut_gnt.delete();
    dut_cdb.delete();
  endtask

  task automatic check_gnts(input string name, input int n, input int e0, input int e1,
                            input int e2, input int e3, input int e4, input int e5);
    int exp_g[6];
    exp_g = '{e0, e1, e2, e3, e4, e5};
    check({name, "_len"}, dut_gnt.size(), n);
    for (int k = 0; k < n; k++)
      check(name, (k < dut_gnt.size()) ? dut_gnt[k] : -99, exp_g[k]);
  endtask

  int issue_seq[6];

  initial begin
    rst = 1'b0; fu_done = '0; fu_issue = '0; cdb_ready = 1'b0; log_en = 0;
    set_fixed_tags();

    // Reset holds grants off even with every FU done.
    fu_done = 4'hF;
    #1;
    check("t1_queued", fu_queued, 0);
    check("t1_valid", cdb_valid, 0);
    check("t1_empty", empty, 1);
    check("t1_count", count, 0);
    tick(); tick();

    // Round robin over four held results.
    rst = 1'b1; cdb_ready = 1'b1; clear_logs(); log_en = 1;
    repeat (6) tick();
    log_en = 0;
    check_gnts("t2_gnt", 6, 0, 1, 2, 3, -1, -1);
    check("t2_cdb_len", dut_cdb.size(), 4);
    for (int k = 0; k < 4; k++)
      check("t2_cdb_tag", (k < dut_cdb.size()) ? dut_cdb[k] : -99, 16 + k);

    // Fairness between FU0 and FU2 with re-issue after each grant.
    fu_done = 4'b0101; clear_logs(); log_en = 1;
    issue_seq = '{4'b0101, 4'b0000, 4'b0001, 4'b0100, 4'b0001, 4'b0100};
    for (int j = 0; j < 6; j++) begin
      fu_issue = 4'(issue_seq[j]);
      tick();
      if (j == 1) check("t3_rr_after_fu0", m_rr, 1);
    end
    log_en = 0;
    check_gnts("t3_gnt", 6, -1, 0, 2, 0, 2, 0);
    fu_issue = '0; fu_done = '0;
    repeat (3) tick();

    // Fill to full with the consumer stalled, then push and pop together.
    cdb_ready = 1'b0; fu_done = 4'hF;
    for (int c = 0; c < 14; c++) begin
      fu_issue = (c % 5 == 0) ? 4'hF : 4'h0;
      tick();
    end
    check("t4_count", count, 8);
    check("t4_full", full, 1);
    check("t4_queued_full", fu_queued, 0);
    cdb_ready = 1'b1;
    #1;
    check("t4_pushpop_grant", fu_queued != 0, 1);
    tick();
    check("t4_count_pushpop", count, 8);
    fu_done = '0;
    repeat (10) tick();
    check("t4_drained", count, 0);

    // Randomized traffic with pointer wrap, stalls and re-issues.
    for (int c = 0; c < 600; c++) begin
      fu_done   = 4'($urandom);
      fu_issue  = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'h0;
      cdb_ready = (c < 300) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
      fu_tag    = 28'($urandom);
      fu_result = {$urandom, $urandom, $urandom, $urandom};
      tick();
    end

    // Async reset mid-operation with five entries queued and rr away from FU0.
    set_fixed_tags();
    fu_done = '0; fu_issue = '0; cdb_ready = 1'b1;
    repeat (10) tick();
    cdb_ready = 1'b0;
    fu_issue = 4'hF; tick();
    fu_issue = 4'h0; fu_done = 4'b0010; tick();
    fu_done = 4'hF; repeat (3) tick();
    fu_issue = 4'b0010; tick();
    fu_issue = 4'h0; tick();
    check("t6_count_before", count, 5);
    @(negedge clk);
    #2;
    rst = 1'b0;
    #1;
    check("t6_count_rst", count, 0);
    check("t6_valid_rst", cdb_valid, 0);
    check("t6_empty_rst", empty, 1);
    check("t6_queued_rst", fu_queued, 0);
    tick(); tick();
    rst = 1'b1; clear_logs(); log_en = 1;
    repeat (2) tick();
    log_en = 0;
    check("t6_regrant0", (dut_gnt.size() > 0) ? dut_gnt[0] : -99, 0);
    check("t6_regrant1", (dut_gnt.size() > 1) ? dut_gnt[1] : -99, 1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
